cnn_seq_op_unit: RTL and testbench

- Sequential, parametrised successor to the ALU's combinational CNN datapath.
- Replaces the zero-detect operand latching with a counted, handshaked operand buffer.
- Computes a KSIZE x KSIZE window with one reusable multiply-accumulate lane. Supported modes are convolution, convolution+ReLU and max-pool.
- Sits beside the ALU. The ALU forwards operand B beats in, and reads the sticky result back on its CNN opcodes.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/cnn_mac_lane.sv | 31 +++
 rtl/cnn_seq_op_unit.sv | 144 ++++++++++++++
 tb/tb_cnn_seq_op_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the sequential CNN operator unit.
// Holds mode codes, FSM states and small sizing helpers.
package cnn_pkg;

   localparam logic [1:0] MODE_CONV = 2'b00;
   localparam logic [1:0] MODE_RELU = 2'b01;
   localparam logic [1:0] MODE_POOL = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COMPUTE = 2'b01,
      DONE    = 2'b10
   } state_t;

   // Element count of a KSIZE x KSIZE window.
   function automatic int calc_n(input int k);
      return k * k;
   endfunction

   // Most negative value of a w-bit accumulator, in the low w bits.
   function automatic logic [63:0] acc_min(input int w);
      return 64'hFFFF_FFFF_FFFF_FFFF << (w - 1);
   endfunction

endpackage

// File: rtl/cnn_mac_lane.sv
// Combinational single-element step: signed MAC or running max.
// Ports: pixel, weight, acc_in, pool_sel in; acc_next out.
module cnn_mac_lane #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic [DATA_W-1:0] pixel,
   input  logic [DATA_W-1:0] weight,
   input  logic [ACC_W-1:0]  acc_in,
   input  logic              pool_sel,
   output logic [ACC_W-1:0]  acc_next
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_x;
   logic signed [ACC_W-1:0]    pix_x;
   logic signed [ACC_W-1:0]    acc_s;

   assign prod   = $signed(pixel) * $signed(weight);
   assign prod_x = ACC_W'(prod);
   assign pix_x  = ACC_W'($signed(pixel));
   assign acc_s  = $signed(acc_in);

   always_comb begin
      acc_next = acc_in + prod_x;
      if (pool_sel) begin
         acc_next = (pix_x > acc_s) ? pix_x : acc_in;
      end
   end

endmodule

// File: rtl/cnn_seq_op_unit.sv
// Sequential KSIZE x KSIZE conv / conv+ReLU / max-pool unit with a
// handshaked operand buffer and one MAC lane; result is sticky.
// Ports: clk, rst (async, active-low), in_valid/in_ready/in_data beat
// input, mode, abort, busy, result_valid pulse, result.
module cnn_seq_op_unit
   import cnn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int KSIZE  = 3,
   parameter int ACC_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [1:0]       mode,
   input  logic             abort,
   output logic             busy,
   output logic             result_valid,
   output logic [ACC_W-1:0] result
);

   localparam int N  = calc_n(KSIZE);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]    LAST    = CW'(N - 1);
   localparam logic [63:0]      MIN64   = acc_min(ACC_W);
   localparam logic [ACC_W-1:0] ACC_MIN = MIN64[ACC_W-1:0];

   state_t state;
   state_t state_nx;

   logic [CW-1:0]     cnt;
   logic [CW-1:0]     idx;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic [1:0]        mode_q;
   logic [1:0]        win_mode;
   logic [DATA_W-1:0] pix [N];
   logic [DATA_W-1:0] wgt [N];
   logic              take;
   logic              pool_sel;
   logic [ACC_W-1:0]  final_val;

   if (2 * DATA_W < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^in_data[31:2*DATA_W];
   end

   // A beat is taken only in IDLE; a coincident abort discards it.
   assign take     = (state == IDLE) && in_valid && !abort;
   // On a one-element window the first beat is also the last.
   assign win_mode = (cnt == '0) ? mode : mode_q;
   assign pool_sel = (mode_q == MODE_POOL);

   cnn_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_lane (
      .pixel    (pix[idx]),
      .weight   (wgt[idx]),
      .acc_in   (acc),
      .pool_sel (pool_sel),
      .acc_next (acc_next)
   );

   assign final_val =
      ((mode_q == MODE_RELU) && acc_next[ACC_W-1]) ? '0 : acc_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (take && cnt == LAST) state_nx = COMPUTE;
         end
         COMPUTE: begin
            if (abort)            state_nx = IDLE;
            else if (idx == LAST) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      busy = (state != IDLE) || (cnt != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         idx          <= '0;
         acc          <= '0;
         mode_q       <= MODE_CONV;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (abort) begin
                  cnt <= '0;
               end else if (in_valid) begin
                  if (cnt == '0) mode_q <= mode;
                  if (cnt == LAST) begin
                     cnt <= '0;
                     idx <= '0;
                     acc <= (win_mode == MODE_POOL) ? ACC_MIN : '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (abort) begin
                  idx <= '0;
               end else begin
                  acc <= acc_next;
                  idx <= idx + 1'b1;
                  // Load on entry to DONE so result is visible with the pulse.
                  if (idx == LAST) begin
                     idx          <= '0;
                     result       <= final_val;
                     result_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (take) begin
         pix[cnt] <= in_data[2*DATA_W-1:DATA_W];
         wgt[cnt] <= in_data[DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_cnn_seq_op_unit.sv
// Directed self-checking bench for cnn_seq_op_unit (defaults, N=9).
// Drives and samples on the falling edge.
module tb_cnn_seq_op_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  mode;
   logic        abort;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] vec [9];

   cnn_seq_op_unit #(
      .DATA_W (8),
      .KSIZE  (3),
      .ACC_W  (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .mode         (mode),
      .abort        (abort),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [31:0] d);
      for (int i = 0; i < 9; i++) vec[i] = d;
   endtask

   // Called at a falling edge; returns at the falling edge after accept.
   task automatic send_beat(input logic [31:0] d);
      int k;
      k = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) check("beat_timeout", 32'(k), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_rv(output int c);
      c = 0;
      while (!result_valid && c < 40) begin
         @(negedge clk);
         c++;
      end
   endtask

   // First beat uses m0, the rest mr; checks latency, value, pulse width.
   task automatic run_window(input string tag, input logic [1:0] m0,
                             input logic [1:0] mr, input logic [31:0] exp);
      int lat;
      for (int i = 0; i < 9; i++) begin
         mode = (i == 0) ? m0 : mr;
         send_beat(vec[i]);
      end
      wait_rv(lat);
      check({tag, "_lat"}, 32'(lat), 32'd9);
      check(tag, result, exp);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(result_valid), 32'd0);
      check({tag, "_hold"}, result, exp);
   endtask

   task automatic count_pulses(input int cyc, output int p);
      p = 0;
      for (int i = 0; i < cyc; i++) begin
         if (result_valid) p++;
         @(negedge clk);
      end
   endtask

   initial begin
      int p;
      int beats;
      int low;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      mode     = 2'b00;
      abort    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_result", result, 32'd0);
      check("rst_rv", 32'(result_valid), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      fill(32'h0102);
      run_window("conv", 2'b00, 2'b00, 32'd18);

      // Abort in IDLE after 4 beats.
      mode = 2'b00;
      for (int i = 0; i < 4; i++) send_beat(32'h0102);
      check("part_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      count_pulses(12, p);
      check("abort_no_rv", 32'(p), 32'd0);
      check("abort_keep", result, 32'd18);

      fill(32'h0303);
      run_window("conv81", 2'b00, 2'b00, 32'd81);

      // Abort together with a beat: that beat must not be counted.
      in_valid = 1'b1;
      in_data  = 32'h7F7F;
      abort    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      abort    = 1'b0;
      check("abort_beat_busy", 32'(busy), 32'd0);
      fill(32'h0202);
      run_window("conv36", 2'b00, 2'b00, 32'd36);

      // Abort in COMPUTE.
      fill(32'h0505);
      for (int i = 0; i < 9; i++) send_beat(vec[i]);
      repeat (2) @(negedge clk);
      check("cmp_ready", 32'(in_ready), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("cabort_ready", 32'(in_ready), 32'd1);
      count_pulses(12, p);
      check("cabort_no_rv", 32'(p), 32'd0);
      check("cabort_keep", result, 32'd36);

      fill(32'h01FF);
      run_window("neg", 2'b00, 2'b00, 32'hFFFF_FFF7);
      run_window("relu", 2'b01, 2'b01, 32'd0);
      fill(32'h0102);
      run_window("rsvd", 2'b11, 2'b11, 32'd18);

      vec[0] = 32'h0555; vec[1] = 32'hFD55; vec[2] = 32'h0755;
      vec[3] = 32'h0055; vec[4] = 32'h8055; vec[5] = 32'h0955;
      vec[6] = 32'h0255; vec[7] = 32'h0155; vec[8] = 32'h0455;
      run_window("pool", 2'b10, 2'b10, 32'd9);
      // Mode flips to conv after the first beat: window stays pool.
      fill(32'h8003);
      run_window("pool_min", 2'b10, 2'b00, 32'hFFFF_FF80);

      // Backpressure: valid held high across two windows.
      mode     = 2'b00;
      in_data  = 32'h0203;
      in_valid = 1'b1;
      beats = 0;
      low   = 0;
      p     = 0;
      for (int i = 0; i < 38; i++) begin
         if (in_ready) beats++;
         else          low++;
         if (result_valid) p++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("bp_beats", 32'(beats), 32'd18);
      check("bp_low", 32'(low), 32'd20);
      check("bp_pulses", 32'(p), 32'd2);
      check("bp_result", result, 32'd54);
      check("bp_idle", 32'(busy), 32'd0);

      // Asynchronous reset in the 5th COMPUTE cycle.
      fill(32'h0102);
      for (int i = 0; i < 9; i++) send_beat(vec[i]);
      repeat (4) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_result", result, 32'd0);
      check("arst_rv", 32'(result_valid), 32'd0);
      check("arst_ready", 32'(in_ready), 32'd1);
      check("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      count_pulses(15, p);
      check("arst_no_rv", 32'(p), 32'd0);
      check("arst_keep", result, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
